fsm_rr_arbiter: RTL and testbench

//  Round-robin arbiter FSM that shares one downstream resource among N requesters.

---
 rtl/fsm_rr_arbiter_if.sv | 22 ++
 rtl/fsm_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_fsm_rr_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fsm_rr_arbiter_if.sv
// Requester/arbiter handshake bundle for fsm_rr_arbiter.
//   req     : level-sensitive request per requester
//   rel     : 1-cycle release strobe from the current owner
//   gnt     : registered one-hot grant, all-zero when nobody owns the resource
//   gnt_id  : index of the current owner, meaningful only while busy=1
//   busy    : high while any grant is asserted
//   timeout : 1-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface fsm_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic           rel;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output req, rel, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, rel, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource among N requesters.
// Grants one registered one-hot owner at a time, revokes a grant after
// MAX_HOLD cycles, and inserts a one-cycle dead gap between owners.
// Ports:
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : fsm_rr_arbiter_if slave modport (req, rel in; gnt, gnt_id, busy, timeout out)
module fsm_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16,
  parameter int HW       = 5
) (
  input  logic              clk,
  input  logic              rst,
  fsm_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t         state_q, state_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic [IDW-1:0] id_q, id_nxt;
  logic [IDW-1:0] last_q, last_nxt;
  logic [HW-1:0]  hold_q, hold_nxt;
  logic           busy_q, busy_nxt;
  logic           to_q, to_nxt;

  logic           any_req;
  logic           found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  int unsigned    cand;

  // Search starts just after the previous owner, so the last owner
  // (including one that just timed out) ranks lowest.
  always_comb begin
    any_req = |bus.req;
    found   = 1'b0;
    win_id  = last_q;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = {{(32-IDW){1'b0}}, last_q} + k;
      if (cand >= N) cand = cand - N;
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        win_id = IDW'(cand);
      end
    end
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    last_nxt  = last_q;
    hold_nxt  = hold_q;
    to_nxt    = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_nxt = GRANT;
          gnt_nxt   = win_oh;
          id_nxt    = win_id;
          last_nxt  = win_id;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      GRANT: begin
        hold_nxt = hold_q + 1'b1;
        // Release (explicit or by dropping req) wins over a coincident timeout.
        if (bus.rel || !bus.req[id_q]) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          to_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
    busy_nxt = |gnt_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      last_q  <= last_nxt;
      hold_q  <= hold_nxt;
      busy_q  <= busy_nxt;
      to_q    <= to_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
module tb_fsm_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fsm_rr_arbiter_if #(.N(4), .IDW(2)) bus ();

  fsm_rr_arbiter #(.N(4), .IDW(2), .MAX_HOLD(16), .HW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic b, input logic t);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(id));
    check({tag, ".busy"},    32'(bus.busy),    32'(b));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] oh;
    bus.req = 4'b1111;
    bus.rel = 1'b0;

    // 1 reset
    #12;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 2 round-robin with rel after 3 grant cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      check("rr_hold", 32'(bus.gnt), 32'(4'b0001 << i));
      bus.rel = 1'b1;
      tick();
      bus.rel = 1'b0;
      expect_out("rr_gap", 4'b0000, 2'(i), 1'b0, 1'b0);
      tick();
      oh = 4'b0001 << ((i + 1) % 4);
      expect_out("rr_next", oh, 2'((i + 1) % 4), 1'b1, 1'b0);
    end

    // 3 timeout: owner 0 drops, requester 2 alone
    bus.req = 4'b0100;
    tick();
    expect_out("drop0_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("to_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.gnt != 4'b0100) break;
      cnt++;
    end
    check("to_len", 32'(cnt), 32'd16);
    expect_out("to_pulse", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    expect_out("to_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // 4 drop: get owner 1, then drop it while 3 and 0 request
    bus.req = 4'b0010;
    tick();
    expect_out("drop2_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    bus.req = 4'b1001;
    tick();
    expect_out("drop1_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("after1", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    expect_out("drop3_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    expect_out("idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // 5 rel in IDLE ignored, then rel coinciding with hold limit
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    expect_out("idle_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    bus.req = 4'b0001;
    tick();
    expect_out("co_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    check("co_last_cycle", 32'(bus.gnt), 32'(4'b0001));
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    expect_out("co_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("co_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6 async reset mid-grant
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b1010;
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
